// File: rtl/sha256_block_ctrl.sv
// rtl/sha256_block_ctrl.sv - SHA-256 block sequencer: load, 64 rounds, accumulate, digest out
module sha256_block_ctrl #(
    parameter int          ROUNDS = 64,
    parameter logic [255:0] H0    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [511:0] blk_data_i,
    input  logic         blk_last_i,
    input  logic         abort_i,
    output logic         sched_load_o,
    output logic [511:0] sched_blk_o,
    output logic         core_load_o,
    output logic         core_en_o,
    output logic [5:0]   round_o,
    output logic [255:0] core_h_o,
    input  logic [255:0] core_wv_i,
    output logic         digest_valid_o,
    input  logic         digest_ready_i,
    output logic [255:0] digest_o,
    output logic [15:0]  blk_cnt_o
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_ACCUM,
        S_OUT
    } state_t;

    state_t         r_state;
    logic [511:0]   r_blk;
    logic           r_last;
    logic [255:0]   r_h;
    logic [255:0]   r_digest;
    logic [15:0]    r_blk_cnt;
    logic [5:0]     r_round;
    logic           r_sched_load;
    logic           r_core_load;
    logic           r_core_en;
    logic           r_digest_valid;
    logic [255:0]   w_h_sum;

    // Feed-forward add is eight independent 32-bit adders; no carry between words.
    always_comb begin
        w_h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_h_sum[i*32 +: 32] = r_h[i*32 +: 32] + core_wv_i[i*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_blk          <= '0;
            r_last         <= 1'b0;
            r_h            <= H0;
            r_digest       <= '0;
            r_blk_cnt      <= '0;
            r_round        <= '0;
            r_sched_load   <= 1'b0;
            r_core_load    <= 1'b0;
            r_core_en      <= 1'b0;
            r_digest_valid <= 1'b0;
        end else begin
            r_sched_load <= 1'b0;
            r_core_load  <= 1'b0;
            if (abort_i) begin
                r_state        <= S_IDLE;
                r_h            <= H0;
                r_blk_cnt      <= '0;
                r_round        <= '0;
                r_core_en      <= 1'b0;
                r_digest_valid <= 1'b0;
                r_digest       <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (blk_valid_i) begin
                            r_blk        <= blk_data_i;
                            r_last       <= blk_last_i;
                            r_sched_load <= 1'b1;
                            r_core_load  <= 1'b1;
                            r_state      <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_core_en <= 1'b1;
                        r_round   <= '0;
                        r_state   <= S_ROUND;
                    end
                    S_ROUND: begin
                        if (r_round == LAST_ROUND) begin
                            r_core_en <= 1'b0;
                            r_round   <= '0;
                            r_state   <= S_ACCUM;
                        end else begin
                            r_round <= r_round + 6'd1;
                        end
                    end
                    S_ACCUM: begin
                        r_h       <= w_h_sum;
                        r_blk_cnt <= r_blk_cnt + 16'd1;
                        if (r_last) begin
                            r_digest       <= w_h_sum;
                            r_digest_valid <= 1'b1;
                            r_state        <= S_OUT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_OUT: begin
                        // Returning to IDLE here means a block can only be taken one cycle later.
                        if (digest_ready_i) begin
                            r_digest_valid <= 1'b0;
                            r_digest       <= '0;
                            r_h            <= H0;
                            r_blk_cnt      <= '0;
                            r_state        <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign blk_ready_o    = (r_state == S_IDLE);
    assign sched_load_o   = r_sched_load;
    assign sched_blk_o    = r_blk;
    assign core_load_o    = r_core_load;
    assign core_en_o      = r_core_en;
    assign round_o        = r_round;
    assign core_h_o       = r_h;
    assign digest_valid_o = r_digest_valid;
    assign digest_o       = r_digest;
    assign blk_cnt_o      = r_blk_cnt;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb/tb_sha256_block_ctrl.sv - bench for sha256_block_ctrl with a behavioural round core
module tb_sha256_block_ctrl;

    localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [2047:0] K_ALL = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] L448_B0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] L448_B1 = {480'd0, 32'h000001c0};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] L448_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] STUB_DIG = 256'h6a09e666bb67ae843c6ef371a54ff539510e527e9b05688b1f83d9aa5be0cd18;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid_i, blk_last_i, abort_i, digest_ready_i;
    logic [511:0] blk_data_i;
    logic         blk_ready_o, sched_load_o, core_load_o, core_en_o, digest_valid_o;
    logic [511:0] sched_blk_o;
    logic [5:0]   round_o;
    logic [255:0] core_h_o, core_wv_i, digest_o;
    logic [15:0]  blk_cnt_o;

    logic         stub_mode = 1'b0;
    logic [31:0]  mw [64];
    logic [255:0] m_wv = '0;
    int           total = 0;
    int           bad   = 0;

    sha256_block_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
        .blk_last_i(blk_last_i), .abort_i(abort_i),
        .sched_load_o(sched_load_o), .sched_blk_o(sched_blk_o),
        .core_load_o(core_load_o), .core_en_o(core_en_o), .round_o(round_o),
        .core_h_o(core_h_o), .core_wv_i(core_wv_i),
        .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready_i),
        .digest_o(digest_o), .blk_cnt_o(blk_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] kword(input int t);
        return K_ALL[2047 - 32*t -: 32];
    endfunction

    function automatic logic [31:0] expand(input logic [31:0] w2, w7, w15, w16);
        return (ror(w2, 17) ^ ror(w2, 19) ^ (w2 >> 10)) + w7 + (ror(w15, 7) ^ ror(w15, 18) ^ (w15 >> 3)) + w16;
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Reference: full FIPS 180-4 compression of one block onto chaining value h.
    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [255:0] s;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = expand(w[t-2], w[t-7], w[t-15], w[t-16]);
        s = h;
        for (int t = 0; t < 64; t++) s = sha_round(s, kword(t), w[t]);
        r = '0;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = h[i*32 +: 32] + s[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [31:0] msg_w(input int t);
        return (t < 16) ? mw[t] : expand(mw[t-2], mw[t-7], mw[t-15], mw[t-16]);
    endfunction

    // Behavioural scheduler + round core reacting to the controller's strobes.
    always @(posedge clk) begin
        if (sched_load_o)
            for (int i = 0; i < 16; i++) mw[i] <= sched_blk_o[511 - 32*i -: 32];
        if (core_load_o)
            m_wv <= core_h_o;
        if (core_en_o) begin
            mw[int'(round_o)] <= msg_w(int'(round_o));
            m_wv <= sha_round(m_wv, kword(int'(round_o)), msg_w(int'(round_o)));
        end
    end

    assign core_wv_i = stub_mode ? {256{1'b1}} : m_wv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Returns one cycle after the handshake edge (cycle 1).
    task automatic send_blk(input logic [511:0] d, input logic l);
        int n = 0;
        blk_valid_i = 1'b1;
        blk_data_i  = d;
        blk_last_i  = l;
        while (!blk_ready_o && n < 300) begin tick(); n++; end
        if (!blk_ready_o) timeout("send_blk");
        tick();
        blk_valid_i = 1'b0;
    endtask

    task automatic get_digest(input int rdy_delay, output logic [255:0] d, output logic [15:0] cnt, output int cyc);
        int n = 0;
        while (!digest_valid_o && n < 300) begin tick(); n++; end
        cyc = n + 1;
        if (!digest_valid_o) timeout("get_digest");
        d   = digest_o;
        cnt = blk_cnt_o;
        repeat (rdy_delay) tick();
        digest_ready_i = 1'b1;
        tick();
        digest_ready_i = 1'b0;
    endtask

    task automatic wait_round(input logic [5:0] r);
        int n = 0;
        while (!(core_en_o && round_o == r) && n < 200) begin tick(); n++; end
        if (!(core_en_o && round_o == r)) timeout("wait_round");
    endtask

    typedef struct {
        int           nblk;
        logic [511:0] blk [2];
        logic         stub;
        logic [255:0] exp_dig;
        logic [15:0]  exp_cnt;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [255:0] d, h_ref;
        logic [15:0]  cnt;
        logic [511:0] rblk;
        int           cyc, n, nb;
        logic         ok;

        vecs[0] = '{nblk: 1, blk: '{ABC_BLK, '0}, stub: 1'b0, exp_dig: ABC_DIG, exp_cnt: 16'd1};
        vecs[1] = '{nblk: 2, blk: '{L448_B0, L448_B1}, stub: 1'b0, exp_dig: L448_DIG, exp_cnt: 16'd2};
        vecs[2] = '{nblk: 1, blk: '{ABC_BLK, '0}, stub: 1'b1, exp_dig: STUB_DIG, exp_cnt: 16'd1};

        rst_n = 1'b0; blk_valid_i = 1'b0; blk_last_i = 1'b0; abort_i = 1'b0;
        digest_ready_i = 1'b0; blk_data_i = '0;
        repeat (3) tick();
        check("reset_ctrl", {blk_ready_o, sched_load_o, core_load_o, core_en_o, digest_valid_o, round_o, blk_cnt_o},
              {1'b1, 4'b0000, 6'd0, 16'd0});
        check("reset_h", core_h_o, H0);
        check("reset_digest", digest_o, '0);
        check("reset_blk", sched_blk_o[255:0] | sched_blk_o[511:256], '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            stub_mode = vecs[i].stub;
            for (int b = 0; b < vecs[i].nblk; b++) begin
                send_blk(vecs[i].blk[b], b == vecs[i].nblk - 1);
                if (b != vecs[i].nblk - 1) begin
                    n = 0;
                    while (!blk_ready_o && n < 300) begin tick(); n++; end
                    check($sformatf("vec%0d_ready_lat", i), n + 1, 67);
                    check($sformatf("vec%0d_mid_cnt", i), blk_cnt_o, b + 1);
                end
            end
            get_digest(i, d, cnt, cyc);
            check($sformatf("vec%0d_digest", i), d, vecs[i].exp_dig);
            check($sformatf("vec%0d_cnt", i), cnt, vecs[i].exp_cnt);
            check($sformatf("vec%0d_lat", i), cyc, 67);
            check($sformatf("vec%0d_after", i), {blk_ready_o, digest_valid_o, blk_cnt_o, core_h_o},
                  {1'b1, 1'b0, 16'd0, H0});
        end

        // Cycle-by-cycle strobe timing with the stub core.
        stub_mode = 1'b1;
        send_blk(ABC_BLK, 1'b1);
        check("t1_load", {sched_load_o, core_load_o, core_en_o, sched_blk_o == ABC_BLK}, 4'b1101);
        tick();
        check("t2_round0", {sched_load_o, core_load_o, core_en_o, round_o}, {3'b001, 6'd0});
        repeat (63) tick();
        check("t65_round63", {core_en_o, round_o}, {1'b1, 6'd63});
        tick();
        check("t66_accum", {core_en_o, round_o, digest_valid_o}, {1'b0, 6'd0, 1'b0});
        tick();
        check("t67_valid", {digest_valid_o, blk_ready_o}, 2'b10);
        check("t67_digest", digest_o, STUB_DIG);

        // Digest held with a pending block; block lands one cycle after the digest handshake.
        blk_valid_i = 1'b1; blk_data_i = ABC_BLK; blk_last_i = 1'b1;
        d  = digest_o;
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (digest_o !== d || blk_ready_o || sched_load_o || !digest_valid_o) ok = 1'b0;
        end
        check("hold_stable", ok, 1'b1);
        digest_ready_i = 1'b1;
        tick();
        digest_ready_i = 1'b0;
        check("hold_release", {blk_ready_o, digest_valid_o, sched_load_o}, 3'b100);
        stub_mode = 1'b0;
        tick();
        blk_valid_i = 1'b0;
        check("hold_accept", {sched_load_o, blk_ready_o}, 2'b10);
        get_digest(0, d, cnt, cyc);
        check("hold_abc", d, ABC_DIG);

        // Abort mid-round of a second block.
        send_blk(ABC_BLK, 1'b0);
        send_blk(ABC_BLK, 1'b1);
        wait_round(6'd30);
        check("abort_pre_cnt", blk_cnt_o, 16'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_state", {blk_ready_o, core_en_o, round_o, blk_cnt_o}, {1'b1, 1'b0, 6'd0, 16'd0});
        check("abort_h", core_h_o, H0);
        blk_valid_i = 1'b1; abort_i = 1'b1;
        tick();
        abort_i = 1'b0; blk_valid_i = 1'b0;
        check("abort_vs_hs", {sched_load_o, blk_ready_o}, 2'b01);
        send_blk(ABC_BLK, 1'b1);
        get_digest(1, d, cnt, cyc);
        check("abort_abc", d, ABC_DIG);

        // Abort while the digest is presented.
        send_blk(ABC_BLK, 1'b1);
        n = 0;
        while (!digest_valid_o && n < 300) begin tick(); n++; end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_out", {digest_valid_o, blk_ready_o, blk_cnt_o}, {2'b01, 16'd0});

        // Asynchronous reset at round 40.
        send_blk(ABC_BLK, 1'b1);
        wait_round(6'd40);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {blk_ready_o, sched_load_o, core_load_o, core_en_o, digest_valid_o, round_o, blk_cnt_o},
              {1'b1, 4'b0000, 6'd0, 16'd0});
        check("rst_h", core_h_o, H0);
        check("rst_blk", sched_blk_o[255:0] | sched_blk_o[511:256], '0);
        repeat (2) tick();
        check("rst_hold", {core_en_o, round_o}, 7'd0);
        rst_n = 1'b1;
        tick();
        send_blk(ABC_BLK, 1'b1);
        get_digest(0, d, cnt, cyc);
        check("rst_abc", d, ABC_DIG);

        // Random multi-block messages against the reference compression.
        for (int m = 0; m < 6; m++) begin
            nb    = $urandom_range(1, 3);
            h_ref = H0;
            for (int b = 0; b < nb; b++) begin
                for (int w = 0; w < 16; w++) rblk[511 - 32*w -: 32] = $urandom();
                h_ref = compress(h_ref, rblk);
                send_blk(rblk, b == nb - 1);
            end
            get_digest($urandom_range(0, 3), d, cnt, cyc);
            check($sformatf("rand%0d_digest", m), d, h_ref);
            check($sformatf("rand%0d_cnt", m), cnt, 16'(nb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
